// File: rtl/col_output_ctrl.sv
// Column-group output collector: per-lane capture registers drained by a fixed-priority
// arbiter into a show-ahead FIFO with a valid/read handshake.
module col_output_ctrl #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned LANES = 8,
    parameter int unsigned DEPTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] in_r [0:LANES-1],
    input  logic [LANES-1:0] in_v,
    input  logic             rread,
    output logic [WIDTH-1:0] out_r,
    output logic             rvalid
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned LW = (LANES > 1) ? $clog2(LANES) : 1;

    logic [WIDTH-1:0] pend_data_q [0:LANES-1];
    logic [LANES-1:0] pend_vld_q, pend_vld_d;
    logic [WIDTH-1:0] mem_q [0:DEPTH-1];
    logic [PW-1:0]    wptr_q, rptr_q;
    logic [PW:0]      count_q, count_d;

    logic          sel_found;
    logic [LW-1:0] sel_idx;
    logic          full, pop, push;

    // Fixed priority: scan from the top so the lowest pending lane wins.
    always_comb begin
        sel_found = 1'b0;
        sel_idx   = '0;
        for (int k = LANES - 1; k >= 0; k--) begin
            if (pend_vld_q[k]) begin
                sel_found = 1'b1;
                sel_idx   = LW'(k);
            end
        end
    end

    assign full   = (count_q == (PW + 1)'(DEPTH));
    assign rvalid = (count_q != '0);
    assign pop    = rread && rvalid;
    // A full FIFO still accepts a push when it is popped on the same edge.
    assign push   = sel_found && (!full || pop);
    assign out_r  = rvalid ? mem_q[rptr_q] : '0;

    // A fresh strobe re-arms the lane even if its old value is drained this edge.
    always_comb begin
        pend_vld_d = pend_vld_q;
        for (int k = 0; k < LANES; k++) begin
            if (in_v[k]) begin
                pend_vld_d[k] = 1'b1;
            end else if (push && (sel_idx == LW'(k))) begin
                pend_vld_d[k] = 1'b0;
            end
        end
    end

    always_comb begin
        count_d = count_q;
        unique case ({push, pop})
            2'b10:   count_d = count_q + (PW + 1)'(1);
            2'b01:   count_d = count_q - (PW + 1)'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pend_vld_q <= '0;
            wptr_q     <= '0;
            rptr_q     <= '0;
            count_q    <= '0;
        end else begin
            pend_vld_q <= pend_vld_d;
            count_q    <= count_d;
            if (push) begin
                wptr_q <= wptr_q + PW'(1);
            end
            if (pop) begin
                rptr_q <= rptr_q + PW'(1);
            end
        end
    end

    // Data storage needs no reset; validity is tracked by the flags and the count.
    always_ff @(posedge clk) begin
        for (int k = 0; k < LANES; k++) begin
            if (in_v[k]) begin
                pend_data_q[k] <= in_r[k];
            end
        end
        if (push && !rst) begin
            mem_q[wptr_q] <= pend_data_q[sel_idx];
        end
    end

endmodule

// File: tb/tb_col_output_ctrl.sv
// Directed bench for col_output_ctrl: inputs change and outputs are observed on the
// falling edge; popped words are collected and compared with hand-computed lists.
module tb_col_output_ctrl;

    logic        clk;
    logic        rst;
    logic [31:0] in_r [0:7];
    logic [7:0]  in_v;
    logic        rread;
    logic [31:0] out_r;
    logic        rvalid;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int first_rv = -1;
    logic [31:0] got [$];
    int          got_cyc [$];
    logic [31:0] exp_q [$];

    col_output_ctrl #(
        .WIDTH(32),
        .LANES(8),
        .DEPTH(8)
    ) dut (
        .clk   (clk),
        .rst   (rst),
        .in_r  (in_r),
        .in_v  (in_v),
        .rread (rread),
        .out_r (out_r),
        .rvalid(rvalid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s got=%0d expected=%0d", tag, act, req);
        end
    endtask

    // One cycle: observe state left by the last rising edge, then drive this cycle's inputs.
    // A word seen with rvalid is popped on the next edge whenever rd is set.
    task automatic step(input logic [7:0] v, input logic rd);
        @(negedge clk);
        if (rvalid && first_rv < 0) first_rv = cyc;
        if (rvalid && rd) begin
            got.push_back(out_r);
            got_cyc.push_back(cyc);
        end
        in_v  = v;
        rread = rd;
        cyc++;
    endtask

    task automatic idle(input int n, input logic rd);
        for (int i = 0; i < n; i++) step(8'h00, rd);
    endtask

    task automatic clear_obs();
        got.delete();
        got_cyc.delete();
        exp_q.delete();
        first_rv = -1;
    endtask

    task automatic check_seq(input string tag);
        check({tag, "_count"}, 32'(got.size()), 32'(exp_q.size()));
        for (int i = 0; i < exp_q.size(); i++) begin
            if (i < got.size()) check($sformatf("%s_word%0d", tag, i), got[i], exp_q[i]);
        end
    endtask

    task automatic load_lanes();
        for (int k = 0; k < 8; k++) in_r[k] = 32'(100 * k + 1);
    endtask

    task automatic exp_lanes();
        for (int k = 0; k < 8; k++) exp_q.push_back(32'(100 * k + 1));
    endtask

    initial begin
        int t0;
        rst   = 1'b1;
        in_v  = 8'hFF;
        rread = 1'b1;
        load_lanes();

        // Reset held two edges with strobes and reads active
        @(negedge clk);
        @(negedge clk);
        check("reset_rvalid", 32'(rvalid), 32'd0);
        check("reset_out_r", out_r, 32'd0);
        rst  = 1'b0;
        in_v = 8'h00;
        clear_obs();
        idle(4, 1'b0);
        check("post_reset_rvalid", 32'(rvalid), 32'd0);

        // One-hot walk
        clear_obs();
        t0 = cyc;
        for (int i = 0; i < 8; i++) step(8'(1 << i), 1'b1);
        idle(12, 1'b1);
        check("walk_latency", 32'(first_rv - t0), 32'd2);
        exp_lanes();
        check_seq("walk");
        check("walk_end_rvalid", 32'(rvalid), 32'd0);

        // All lanes at once, continuous read
        clear_obs();
        step(8'hFF, 1'b1);
        idle(12, 1'b1);
        exp_lanes();
        check_seq("simul");
        if (got_cyc.size() == 8) check("simul_back_to_back", 32'(got_cyc[7] - got_cyc[0]), 32'd7);

        // Back-pressure: fill, then one more on lane 3
        clear_obs();
        step(8'hFF, 1'b0);
        idle(9, 1'b0);
        in_r[3] = 32'd999;
        step(8'h08, 1'b0);
        idle(6, 1'b0);
        check("full_rvalid", 32'(rvalid), 32'd1);
        check("full_head", out_r, 32'd1);
        idle(15, 1'b1);
        exp_lanes();
        exp_q.push_back(32'd999);
        check_seq("bp");

        // Overwrite of a stalled lane
        clear_obs();
        load_lanes();
        step(8'hFF, 1'b0);
        idle(9, 1'b0);
        in_r[2] = 32'd5;
        step(8'h04, 1'b0);
        in_r[2] = 32'd7;
        step(8'h04, 1'b0);
        idle(3, 1'b0);
        idle(15, 1'b1);
        load_lanes();
        exp_lanes();
        exp_q.push_back(32'd7);
        check_seq("ovw");

        // Read on an empty FIFO
        clear_obs();
        idle(3, 1'b1);
        check("empty_rvalid", 32'(rvalid), 32'd0);
        check("empty_out_r", out_r, 32'd0);
        check("empty_no_words", 32'(got.size()), 32'd0);

        // Stream across pointer wrap
        clear_obs();
        for (int i = 0; i < 20; i++) begin
            in_r[i % 8] = 32'(1000 + i);
            exp_q.push_back(32'(1000 + i));
            step(8'(1 << (i % 8)), 1'b1);
        end
        idle(5, 1'b1);
        check_seq("wrap");
        check("wrap_end_rvalid", 32'(rvalid), 32'd0);

        // Mid-operation reset discards FIFO contents and pending lanes
        clear_obs();
        load_lanes();
        step(8'hFF, 1'b0);
        idle(2, 1'b0);
        rst = 1'b1;
        idle(1, 1'b0);
        rst = 1'b0;
        check("midrst_rvalid", 32'(rvalid), 32'd0);
        idle(4, 1'b1);
        check("midrst_no_words", 32'(got.size()), 32'd0);
        check("midrst_end_rvalid", 32'(rvalid), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
